// File: rtl/prog_mem_loader.sv
// prog_mem_loader: 2**AW x WW unified instruction/data memory for the core.
// A host streams a program image in over a valid/ready byte port. The image
// is one count byte followed by a hi/lo byte pair per word. The core is held
// in reset until the last word has been written.
module prog_mem_loader #(
    parameter int unsigned AW = 8,
    parameter int unsigned WW = 15,
    parameter int unsigned DW = 8
) (
    input  logic          ph1,
    input  logic          reset,
    input  logic          load_start,
    input  logic          load_valid,
    input  logic [7:0]    load_byte,
    output logic          load_ready,
    output logic          cpu_reset,
    output logic          busy,
    output logic [AW:0]   words_loaded,
    input  logic [AW-1:0] cpu_adr,
    input  logic          cpu_we,
    input  logic [DW-1:0] cpu_wdata,
    output logic [WW-1:0] cpu_rdata
);

    localparam logic [1:0] HDR = 2'd0;
    localparam logic [1:0] HI  = 2'd1;
    localparam logic [1:0] LO  = 2'd2;
    localparam logic [1:0] RUN = 2'd3;

    localparam int unsigned HW = WW - DW;  // width of the hi part of a word

    logic [1:0]    state_q, state_d;
    logic [AW:0]   remaining_q, remaining_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [HW-1:0] hi_q, hi_d;
    logic [AW:0]   words_q, words_d;
    logic          cpu_reset_q, cpu_reset_d;
    logic          xfer;
    logic [AW:0]   hdr_count;

    logic [WW-1:0] mem [2**AW];

    assign load_ready   = (state_q != RUN) & ~load_start;
    assign xfer         = load_valid & load_ready;
    assign busy         = (state_q != RUN);
    assign cpu_reset    = cpu_reset_q;
    assign words_loaded = words_q;
    assign cpu_rdata    = mem[cpu_adr];

    // A count byte of zero stands for a full memory image.
    assign hdr_count = (load_byte == 8'd0) ? (AW+1)'(2**AW) : (AW+1)'(load_byte);

    // Next-state logic for the loader FSM and its counters
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        hi_d        = hi_q;
        words_d     = words_q;
        if (load_start) begin
            // Restart: drop any half-received word; memory keeps what was written.
            state_d = HDR;
            hi_d    = '0;
        end else if (xfer) begin
            case (state_q)
                HDR: begin
                    remaining_d = hdr_count;
                    addr_d      = '0;
                    words_d     = '0;
                    state_d     = HI;
                end
                HI: begin
                    hi_d    = load_byte[HW-1:0];
                    state_d = LO;
                end
                LO: begin
                    addr_d      = addr_q + 1'b1;
                    words_d     = words_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    state_d     = (remaining_q == (AW+1)'(1)) ? RUN : HI;
                end
                default: ;
            endcase
        end
        cpu_reset_d = (state_d != RUN);
    end

    // Loader state registers with asynchronous reset
    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            state_q     <= HDR;
            remaining_q <= '0;
            addr_q      <= '0;
            hi_q        <= '0;
            words_q     <= '0;
            cpu_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            hi_q        <= hi_d;
            words_q     <= words_d;
            cpu_reset_q <= cpu_reset_d;
        end
    end

    // Single write port: loader writes only while the core is held in reset,
    // core writes only while it is running, so the two never collide.
    always_ff @(posedge ph1) begin
        if (xfer && state_q == LO) begin
            mem[addr_q] <= {hi_q, load_byte[DW-1:0]};
        end else if (cpu_we && !cpu_reset_q) begin
            mem[cpu_adr][DW-1:0] <= cpu_wdata;
        end
    end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Testbench for prog_mem_loader: loads images over the byte port, checks the
// memory contents through the processor read port against a scoreboard, and
// exercises CPU writes, restart, gaps and asynchronous reset.
module tb_prog_mem_loader;

    logic        ph1 = 1'b0;
    logic        reset = 1'b1;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic [7:0]  load_byte = 8'h00;
    logic        load_ready;
    logic        cpu_reset;
    logic        busy;
    logic [8:0]  words_loaded;
    logic [7:0]  cpu_adr = 8'h00;
    logic        cpu_we = 1'b0;
    logic [7:0]  cpu_wdata = 8'h00;
    logic [14:0] cpu_rdata;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [7:0]  adr;
        logic [14:0] data;
    } sb_entry_t;

    sb_entry_t sb[$];

    typedef struct {
        logic [7:0]  adr;
        logic        we;
        logic [7:0]  wdata;
        logic [14:0] exp_before;
        logic [14:0] exp_after;
    } vec_t;

    prog_mem_loader dut (
        .ph1          (ph1),
        .reset        (reset),
        .load_start   (load_start),
        .load_valid   (load_valid),
        .load_byte    (load_byte),
        .load_ready   (load_ready),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .words_loaded (words_loaded),
        .cpu_adr      (cpu_adr),
        .cpu_we       (cpu_we),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata)
    );

    always #5 ph1 = ~ph1;

    initial begin
        #500000;
        $display("FAIL timeout: got still running want finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Offer one byte, optionally after a gap of idle cycles with junk on the bus.
    task automatic send_byte(input logic [7:0] b, input int gap = 0);
        int n = 0;
        for (int i = 0; i < gap; i++) begin
            @(negedge ph1);
            load_valid = 1'b0;
            load_byte  = 8'hAA;
        end
        @(negedge ph1);
        load_valid = 1'b1;
        load_byte  = b;
        while (!load_ready && n < 20) begin
            @(negedge ph1);
            n++;
        end
        if (!load_ready) begin
            chk("ready_wait", {31'd0, load_ready}, 32'd1);
            load_valid = 1'b0;
            return;
        end
        @(posedge ph1);
        #1;
        load_valid = 1'b0;
    endtask

    task automatic load_word(input logic [7:0] adr, input logic [7:0] hi, input logic [7:0] lo);
        sb_entry_t e;
        send_byte(hi);
        send_byte(lo);
        e.adr  = adr;
        e.data = {hi[6:0], lo};
        sb.push_back(e);
    endtask

    task automatic drain();
        sb_entry_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge ph1);
            cpu_adr = e.adr;
            #1;
            chk($sformatf("mem[%0d]", e.adr), {17'd0, cpu_rdata}, {17'd0, e.data});
        end
    endtask

    task automatic pulse_start();
        @(negedge ph1);
        load_start = 1'b1;
        #1;
        chk("ready_during_start", {31'd0, load_ready}, 32'd0);
        @(posedge ph1);
        #1;
        load_start = 1'b0;
        @(negedge ph1);
        chk("cpu_reset_after_start", {31'd0, cpu_reset}, 32'd1);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    initial begin
        vec_t vecs[5];
        logic [7:0] kb;

        vecs[0] = '{adr: 8'd1, we: 1'b1, wdata: 8'h5A, exp_before: 15'h7FFF, exp_after: 15'h7F5A};
        vecs[1] = '{adr: 8'd0, we: 1'b0, wdata: 8'h00, exp_before: 15'h4123, exp_after: 15'h4123};
        vecs[2] = '{adr: 8'd0, we: 1'b1, wdata: 8'hC3, exp_before: 15'h4123, exp_after: 15'h41C3};
        vecs[3] = '{adr: 8'd1, we: 1'b0, wdata: 8'hFF, exp_before: 15'h7F5A, exp_after: 15'h7F5A};
        vecs[4] = '{adr: 8'd1, we: 1'b1, wdata: 8'h00, exp_before: 15'h7F5A, exp_after: 15'h7F00};

        // Reset values
        repeat (2) @(negedge ph1);
        chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_ready", {31'd0, load_ready}, 32'd1);
        chk("rst_words", {23'd0, words_loaded}, 32'd0);
        reset = 1'b0;

        // Two-word image
        send_byte(8'h02);
        load_word(8'd0, 8'h41, 8'h23);
        send_byte(8'h7F);
        @(negedge ph1);
        chk("t1_cpu_reset_before_last", {31'd0, cpu_reset}, 32'd1);
        send_byte(8'hFF);
        sb.push_back('{adr: 8'd1, data: 15'h7FFF});
        @(negedge ph1);
        chk("t1_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        chk("t1_words", {23'd0, words_loaded}, 32'd2);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        chk("t1_ready", {31'd0, load_ready}, 32'd0);
        drain();

        // Processor reads/writes in RUN; also valid held high must be ignored
        load_valid = 1'b1;
        load_byte  = 8'h33;
        for (int i = 0; i < 5; i++) begin
            @(negedge ph1);
            cpu_adr   = vecs[i].adr;
            cpu_we    = vecs[i].we;
            cpu_wdata = vecs[i].wdata;
            #1;
            chk($sformatf("vec%0d_before", i), {17'd0, cpu_rdata}, {17'd0, vecs[i].exp_before});
            @(posedge ph1);
            #1;
            cpu_we = 1'b0;
            chk($sformatf("vec%0d_after", i), {17'd0, cpu_rdata}, {17'd0, vecs[i].exp_after});
        end
        load_valid = 1'b0;
        @(negedge ph1);
        chk("run_valid_ignored_busy", {31'd0, busy}, 32'd0);
        chk("run_valid_ignored_words", {23'd0, words_loaded}, 32'd2);

        // Full 256-word image with header 0
        pulse_start();
        send_byte(8'h00);
        for (int k = 0; k < 255; k++) begin
            kb = 8'(k);
            load_word(kb, kb, kb);
        end
        @(negedge ph1);
        chk("t2_busy_before_last", {31'd0, busy}, 32'd1);
        chk("t2_words_before_last", {23'd0, words_loaded}, 32'd255);
        load_word(8'd255, 8'hFF, 8'hFF);
        @(negedge ph1);
        chk("t2_busy", {31'd0, busy}, 32'd0);
        chk("t2_words", {23'd0, words_loaded}, 32'd256);
        chk("t2_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        drain();

        // Restart in mid-word
        pulse_start();
        send_byte(8'h03);
        load_word(8'd0, 8'h12, 8'h34);
        send_byte(8'h56);
        @(negedge ph1);
        load_start = 1'b1;
        load_valid = 1'b1;
        load_byte  = 8'h99;
        #1;
        chk("t4_ready_on_start", {31'd0, load_ready}, 32'd0);
        @(posedge ph1);
        #1;
        load_start = 1'b0;
        load_valid = 1'b0;
        @(negedge ph1);
        chk("t4_words_kept", {23'd0, words_loaded}, 32'd1);
        chk("t4_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        sb.push_back('{adr: 8'd1, data: 15'h0101});
        drain();
        send_byte(8'h01);
        load_word(8'd0, 8'h05, 8'h66);
        @(negedge ph1);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_words", {23'd0, words_loaded}, 32'd1);
        drain();

        // Gaps between bytes, hi bit 7 dropped
        pulse_start();
        send_byte(8'h01, 3);
        send_byte(8'h80, 2);
        @(negedge ph1);
        chk("t5_busy_mid", {31'd0, busy}, 32'd1);
        send_byte(8'h01, 4);
        sb.push_back('{adr: 8'd0, data: 15'h0001});
        @(negedge ph1);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_words", {23'd0, words_loaded}, 32'd1);
        drain();

        // Asynchronous reset between hi and lo bytes
        pulse_start();
        send_byte(8'h02);
        load_word(8'd0, 8'h11, 8'h22);
        send_byte(8'h33);
        @(negedge ph1);
        chk("t6_words_pre", {23'd0, words_loaded}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("t6_words", {23'd0, words_loaded}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd1);
        chk("t6_ready", {31'd0, load_ready}, 32'd1);
        cpu_adr   = 8'd0;
        cpu_we    = 1'b1;
        cpu_wdata = 8'hEE;
        repeat (2) @(negedge ph1);
        reset = 1'b0;
        repeat (3) @(negedge ph1);
        cpu_we = 1'b0;
        sb.push_back('{adr: 8'd1, data: 15'h0101});
        drain();
        // Header must be resent after reset
        send_byte(8'h01);
        load_word(8'd0, 8'h0A, 8'hBC);
        @(negedge ph1);
        chk("t6_reload_busy", {31'd0, busy}, 32'd0);
        chk("t6_reload_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
